// File: rtl/sha3_scan_result_collector.sv
// Buffers scanner results in a small FIFO and serialises each onto a 32-bit valid/ready stream.
// Optional macro SHA3_RESULT_HASH_OUT_EN: store and emit the 25x64 hash after the nonce (51 words per result).
module sha3_scan_result_collector #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   found,
  input  logic [31:0]            nonce,
  input  logic [24:0][63:0]      hash,
  output logic [31:0]            dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [$clog2(DEPTH):0] pending,
  output logic [DROP_W-1:0]      dropped,
  output logic                   busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = 6;
`ifdef SHA3_RESULT_HASH_OUT_EN
  localparam logic [IW-1:0] LAST_IDX = IW'(50);
`else
  localparam logic [IW-1:0] LAST_IDX = IW'(0);
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_d;
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_next;
  logic [IW-1:0]   idx, idx_d;
  logic [31:0]     dout_d, hash_word;
  logic [PW-1:0]   pending_d;
  logic            hs_c, last_c, pop_c, full_c, push_c, drop_c;

  logic [31:0]     nonce_mem [DEPTH];
`ifdef SHA3_RESULT_HASH_OUT_EN
  logic [24:0][63:0] hash_mem [DEPTH];
`endif

  assign hs_c    = dout_valid && dout_ready;
  assign last_c  = (idx == LAST_IDX);
  assign pop_c   = hs_c && last_c;
  assign full_c  = (pending == PW'(DEPTH));
  assign push_c  = found && (!full_c || pop_c);
  assign drop_c  = found && full_c && !pop_c;
  assign rd_next = rd_ptr + AW'(1);

  // Word following the current one: lane idx/2, high half when idx is odd
`ifdef SHA3_RESULT_HASH_OUT_EN
  assign hash_word = idx[0] ? hash_mem[rd_ptr][idx[IW-1:1]][63:32]
                            : hash_mem[rd_ptr][idx[IW-1:1]][31:0];
`else
  logic unused_hash;
  assign unused_hash = ^hash;
  assign hash_word   = '0;
`endif

  always_comb begin
    pending_d = pending;
    if (push_c && !pop_c)      pending_d = pending + PW'(1);
    else if (pop_c && !push_c) pending_d = pending - PW'(1);
  end

  // FIFO storage; the entry being sent is only overwritten on its final handshake
  always_ff @(posedge clk) begin
    if (push_c) begin
      nonce_mem[wr_ptr] <= nonce;
`ifdef SHA3_RESULT_HASH_OUT_EN
      hash_mem[wr_ptr]  <= hash;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pending    <= '0;
      dropped    <= '0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      dout       <= dout_d;
      dout_valid <= (state_d == SEND);
      busy       <= (state_d == SEND);
      pending    <= pending_d;
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_next;
      if (drop_c && (dropped != {DROP_W{1'b1}})) dropped <= dropped + DROP_W'(1);
    end
  end

  // Next state and next stream word; a push landing on the pop edge is bypassed from the inputs
  always_comb begin
    state_d = state;
    idx_d   = idx;
    dout_d  = dout;
    case (state)
      IDLE: begin
        if (pending != '0) begin
          state_d = SEND;
          idx_d   = '0;
          dout_d  = nonce_mem[rd_ptr];
        end
      end
      SEND: begin
        if (hs_c) begin
          if (last_c) begin
            idx_d = '0;
            if (pending_d != '0) begin
              dout_d = (pending == PW'(1)) ? nonce : nonce_mem[rd_next];
            end else begin
              state_d = IDLE;
              dout_d  = '0;
            end
          end else begin
            idx_d  = idx + IW'(1);
            dout_d = hash_word;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sha3_scan_result_collector.sv
// Scoreboard bench for sha3_scan_result_collector; follows SHA3_RESULT_HASH_OUT_EN for words per result.
module tb_sha3_scan_result_collector;

`ifdef SHA3_RESULT_HASH_OUT_EN
  localparam int NW = 51;
`else
  localparam int NW = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             found;
  logic [31:0]      nonce;
  logic [24:0][63:0] hash;
  logic             dout_ready;
  logic [31:0]      dout, dout_s;
  logic             dout_valid, dout_valid_s;
  logic [2:0]       pending, pending_s;
  logic [15:0]      dropped;
  logic [1:0]       dropped_s;
  logic             busy, busy_s;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_dout = '0;

  sha3_scan_result_collector #(.DEPTH(4), .DROP_W(16)) dut (
    .clk(clk), .rst(rst), .found(found), .nonce(nonce), .hash(hash),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .pending(pending), .dropped(dropped), .busy(busy)
  );

  sha3_scan_result_collector #(.DEPTH(4), .DROP_W(2)) dut_sat (
    .clk(clk), .rst(rst), .found(found), .nonce(nonce), .hash(hash),
    .dout(dout_s), .dout_valid(dout_valid_s), .dout_ready(dout_ready),
    .pending(pending_s), .dropped(dropped_s), .busy(busy_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] lane_of(input logic [31:0] n, input int k);
    if (n == 32'hDEADBEEF) return {32'(k), 32'h1000_0000 | 32'(k)};
    return {n ^ 32'(k), n + 32'(k * 7)};
  endfunction

  task automatic push_exp(input logic [31:0] n);
    logic [63:0] l;
    q.push_back(n);
    if (NW > 1) begin
      for (int k = 0; k < 25; k++) begin
        l = lane_of(n, k);
        q.push_back(l[31:0]);
        q.push_back(l[63:32]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle found strobe; inputs are scrambled once found drops
  task automatic pulse(input logic [31:0] n, input bit acc);
    found = 1'b1;
    nonce = n;
    for (int k = 0; k < 25; k++) hash[k] = lane_of(n, k);
    if (acc) push_exp(n);
    tick();
    found = 1'b0;
    nonce = $urandom;
    for (int k = 0; k < 25; k++) hash[k] = {$urandom, $urandom};
  endtask

  // pat 0: ready held high; pat 1: ready 1,0,0 repeating
  task automatic drain(input int pat, input int budget);
    int c = 0;
    while ((q.size() != 0 || dout_valid) && c < budget) begin
      dout_ready = (pat == 0) ? 1'b1 : ((c % 3) == 0);
      tick();
      c++;
    end
    dout_ready = 1'b0;
    check("drain_timeout", 32'(c >= budget), 32'd0);
    check("queue_empty", 32'(q.size()), 32'd0);
  endtask

  // Scoreboard and stall-stability monitor, sampled mid-cycle
  always @(negedge clk) begin
    logic [31:0] exp;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_data", dout, prev_dout);
        check("hold_valid", 32'(dout_valid), 32'd1);
      end
      if (dout_valid && dout_ready) begin
        if (q.size() == 0) begin
          check("word_unexpected", 32'(q.size()), 32'd1);
        end else begin
          exp = q.pop_front();
          check("word", dout, exp);
        end
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
    end
  end

  initial begin
    rst = 1'b1; found = 1'b0; dout_ready = 1'b0; nonce = '0; hash = '0;
    repeat (2) tick();
    check("rst_dout", dout, 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Single result, minimum latency
    dout_ready = 1'b1;
    pulse(32'hDEADBEEF, 1'b1);
    check("lat_pending", 32'(pending), 32'd1);
    check("lat_valid_early", 32'(dout_valid), 32'd0);
    tick();
    check("lat_valid", 32'(dout_valid), 32'd1);
    check("lat_busy", 32'(busy), 32'd1);
    drain(0, 200);
    check("single_pending", 32'(pending), 32'd0);
    check("single_busy", 32'(busy), 32'd0);

    // Backpressure
    dout_ready = 1'b0;
    pulse(32'hDEADBEEF, 1'b1);
    drain(1, 400);

    // Overflow: six back-to-back strobes with the consumer stalled
    dout_ready = 1'b0;
    for (int i = 0; i < 6; i++) pulse(32'hA000_0001 + 32'(i), i < 4);
    check("ovf_pending", 32'(pending), 32'd4);
    check("ovf_dropped", 32'(dropped), 32'd2);
    check("ovf_dropped_sat", 32'(dropped_s), 32'd2);
    check("ovf_busy", 32'(busy), 32'd1);
    drain(0, 400);

    // Full FIFO with a push on the final-word handshake edge
    for (int i = 0; i < 4; i++) pulse(32'hB000_0001 + 32'(i), 1'b1);
    check("fullpop_pre", 32'(pending), 32'd4);
    dout_ready = 1'b1;
    repeat (NW - 1) tick();
    pulse(32'hC0DE_0005, 1'b1);
    check("fullpop_pending", 32'(pending), 32'd4);
    check("fullpop_dropped", 32'(dropped), 32'd2);
    drain(0, 600);

    // Drop-counter saturation on the 2-bit instance
    dout_ready = 1'b0;
    for (int i = 0; i < 9; i++) pulse(32'hD000_0001 + 32'(i), i < 4);
    check("sat_pending", 32'(pending), 32'd4);
    check("sat_dropped", 32'(dropped), 32'd7);
    check("sat_dropped_sat", 32'(dropped_s), 32'd3);
    drain(0, 400);

    // Reset in the middle of a transfer
    dout_ready = 1'b0;
    pulse(32'hE000_0001, 1'b1);
    pulse(32'hE000_0002, 1'b1);
    dout_ready = 1'b1;
    repeat ((NW > 1) ? 20 : 0) tick();
    dout_ready = 1'b0;
    check("mid_valid", 32'(dout_valid), 32'd1);
    rst = 1'b1;
    q.delete();
    #1;
    check("mrst_dout", dout, 32'd0);
    check("mrst_valid", 32'(dout_valid), 32'd0);
    check("mrst_pending", 32'(pending), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_dropped", 32'(dropped), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    pulse(32'hFACE_0001, 1'b1);
    drain(0, 200);
    check("post_pending", 32'(pending), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
